// File: rtl/io_write_buffer_if.sv
// io_write_buffer_if: CPU-side and RAM/HCI-side bus signals of the I/O write buffer.
interface io_write_buffer_if;
    logic        rdy;
    logic        cpu_valid;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        cpu_stall;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    modport master (
        output rdy, cpu_valid, cpu_a, cpu_dout, cpu_wr, mem_din, io_buffer_full,
        input  cpu_din, cpu_stall, mem_a, mem_dout, mem_wr
    );
    modport slave (
        input  rdy, cpu_valid, cpu_a, cpu_dout, cpu_wr, mem_din, io_buffer_full,
        output cpu_din, cpu_stall, mem_a, mem_dout, mem_wr
    );
endinterface

// File: rtl/io_write_buffer.sv
// io_write_buffer: CPU-to-RAM/HCI bridge that queues I/O writes while the UART buffer is busy,
// keeping RAM accesses and I/O reads strictly behind any queued write.
module io_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    io_write_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [17:0]   addr_q [DEPTH];
    logic [7:0]    data_q [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          cool;
    logic          go, empty, full, io_wr, can_io, pass, direct, drain, push;

    // cool masks the cycle where io_buffer_full has not yet caught up with the last I/O write
    always_comb begin
        go     = !rst && bus.rdy;
        empty  = count == '0;
        full   = count == CW'(DEPTH);
        io_wr  = bus.cpu_valid && bus.cpu_wr && bus.cpu_a[17:16] == 2'b11;
        can_io = !bus.io_buffer_full && !cool;
        pass   = go && empty && bus.cpu_valid && !io_wr;
        direct = go && empty && io_wr && can_io;
        drain  = go && !empty && can_io;
        push   = go && io_wr && !direct && (!full || drain);
    end

    assign bus.cpu_stall = !go || (bus.cpu_valid && !empty && !io_wr) || (io_wr && !direct && !push);
    assign bus.mem_a     = pass || direct ? bus.cpu_a : drain ? {14'b0, addr_q[head]} : '0;
    assign bus.mem_dout  = pass || direct ? bus.cpu_dout : drain ? data_q[head] : '0;
    assign bus.mem_wr    = pass ? bus.cpu_wr : direct || drain;
    assign bus.cpu_din   = bus.mem_din;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= bus.cpu_a[17:0];
            data_q[tail] <= bus.cpu_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            cool  <= 1'b0;
        end else if (bus.rdy) begin
            head  <= drain ? head + PW'(1) : head;
            tail  <= push ? tail + PW'(1) : tail;
            count <= count + CW'(push) - CW'(drain);
            cool  <= direct || drain;
        end
    end
endmodule
